// File: rtl/crono_pkg.sv
// Shared definitions for the countdown timer: state encoding, BCD limits and
// the legal-time check used when a programmed value is captured.
package crono_pkg;

  // PAUSE only becomes reachable when CRONO_PAUSE_EN is defined
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROG  = 3'd1,
    ST_RUN   = 3'd2,
    ST_RING  = 3'd3,
    ST_PAUSE = 3'd4
  } crono_state_t;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_HH = 8'h23;

  function automatic logic bcd_hms_legal(input logic [7:0] hh,
                                         input logic [7:0] mm,
                                         input logic [7:0] ss);
    return (hh[3:0] <= 4'd9) && (mm[3:0] <= 4'd9) && (ss[3:0] <= 4'd9) &&
           (mm[7:4] <= 4'd5) && (ss[7:4] <= 4'd5) && (hh <= BCD_MAX_HH);
  endfunction

endpackage

// File: rtl/bcd_hms_dec.sv
// Combinational one-second BCD decrement of hh:mm:ss with borrow ss->mm->hh.
// 00:00:00 saturates; zero flags when the decremented result is 00:00:00.
module bcd_hms_dec
  import crono_pkg::*;
(
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  output logic [7:0] hh_dec,
  output logic [7:0] mm_dec,
  output logic [7:0] ss_dec,
  output logic       zero
);

  // Two-digit BCD decrement; bit 8 is the borrow out, wrap is the value after borrow
  function automatic logic [8:0] bcd2_dec(input logic [7:0] v, input logic [7:0] wrap);
    if (v[3:0] != 4'd0)
      return {1'b0, v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'd0)
      return {1'b0, v[7:4] - 4'd1, 4'd9};
    else
      return {1'b1, wrap};
  endfunction

  logic [8:0] ss_res;
  logic [8:0] mm_res;
  logic [8:0] hh_res;
  logic       in_zero;

  always_comb begin
    in_zero = (hh == 8'h00) && (mm == 8'h00) && (ss == 8'h00);
    ss_res  = bcd2_dec(ss, BCD_MAX_MS);
    mm_res  = ss_res[8] ? bcd2_dec(mm, BCD_MAX_MS) : {1'b0, mm};
    hh_res  = mm_res[8] ? bcd2_dec(hh, BCD_MAX_HH) : {1'b0, hh};
    if (in_zero) begin
      hh_dec = 8'h00;
      mm_dec = 8'h00;
      ss_dec = 8'h00;
    end else begin
      hh_dec = hh_res[7:0];
      mm_dec = mm_res[7:0];
      ss_dec = ss_res[7:0];
    end
    zero = (hh_dec == 8'h00) && (mm_dec == 8'h00) && (ss_dec == 8'h00);
  end

endmodule

// File: rtl/crono_countdown_ctrl.sv
// Countdown timer sequencer: program, run on a 1 s tick, ring on expiry.
// Define CRONO_PAUSE_EN to let iniciar toggle RUN/PAUSE.
module crono_countdown_ctrl
  import crono_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned RING_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       programar,
  input  logic       iniciar,
  input  logic       load_valid,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       ring_ack,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       crono_activo,
  output logic       ring,
  output logic       finalizo,
  output logic [1:0] state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        RING_LAST = 8'(RING_SECS - 1);

  crono_state_t      state_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [7:0]        ring_cnt_reg;

  logic [7:0] hh_dec, mm_dec, ss_dec;
  logic       dec_zero;
  logic       tick;
  logic       load_ok;
  logic       start_nonzero;

  bcd_hms_dec u_dec (
    .hh     (hh),
    .mm     (mm),
    .ss     (ss),
    .hh_dec (hh_dec),
    .mm_dec (mm_dec),
    .ss_dec (ss_dec),
    .zero   (dec_zero)
  );

  assign tick    = (tick_cnt_reg == TICK_LAST);
  assign load_ok = load_valid && bcd_hms_legal(load_hh, load_mm, load_ss);
  // A load in the same cycle as iniciar is what gets started
  assign start_nonzero = load_ok ? (|{load_hh, load_mm, load_ss}) : (|{hh, mm, ss});
  assign state = (state_reg == ST_PAUSE) ? 2'd2 : state_reg[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      hh           <= 8'h00;
      mm           <= 8'h00;
      ss           <= 8'h00;
      crono_activo <= 1'b0;
      ring         <= 1'b0;
      finalizo     <= 1'b0;
      tick_cnt_reg <= '0;
      ring_cnt_reg <= 8'h00;
    end else begin
      finalizo <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (programar) state_reg <= ST_PROG;
        end
        ST_PROG: begin
          if (load_ok) begin
            hh <= load_hh;
            mm <= load_mm;
            ss <= load_ss;
          end
          if (iniciar && start_nonzero) begin
            state_reg    <= ST_RUN;
            crono_activo <= 1'b1;
            tick_cnt_reg <= '0;
          end
        end
        ST_RUN: begin
          if (programar) begin
            state_reg    <= ST_PROG;
            crono_activo <= 1'b0;
`ifdef CRONO_PAUSE_EN
          end else if (iniciar) begin
            state_reg <= ST_PAUSE;
`endif
          end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            if (tick) begin
              hh <= hh_dec;
              mm <= mm_dec;
              ss <= ss_dec;
              if (dec_zero) begin
                state_reg    <= ST_RING;
                crono_activo <= 1'b0;
                ring         <= 1'b1;
                finalizo     <= 1'b1;
                ring_cnt_reg <= 8'h00;
              end
            end
          end
        end
        ST_RING: begin
          if (programar) begin
            state_reg <= ST_PROG;
            ring      <= 1'b0;
          end else if (ring_ack) begin
            state_reg <= ST_IDLE;
            ring      <= 1'b0;
          end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            if (tick) begin
              if (ring_cnt_reg == RING_LAST) begin
                state_reg <= ST_IDLE;
                ring      <= 1'b0;
              end else begin
                ring_cnt_reg <= ring_cnt_reg + 8'd1;
              end
            end
          end
        end
`ifdef CRONO_PAUSE_EN
        ST_PAUSE: begin
          // Tick counter is deliberately left untouched so the phase survives
          if (programar) begin
            state_reg    <= ST_PROG;
            crono_activo <= 1'b0;
          end else if (iniciar) begin
            state_reg <= ST_RUN;
          end
        end
`endif
        default: begin
          state_reg    <= ST_IDLE;
          crono_activo <= 1'b0;
          ring         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crono_countdown_ctrl.sv
// Directed bench for crono_countdown_ctrl with TICK_DIV=4, RING_SECS=2.
// Pause steps are exercised when CRONO_PAUSE_EN is defined.
module tb_crono_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       programar = 1'b0;
  logic       iniciar = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_hh = 8'h00;
  logic [7:0] load_mm = 8'h00;
  logic [7:0] load_ss = 8'h00;
  logic       ring_ack = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       crono_activo, ring, finalizo;
  logic [1:0] state;

  int n_checks = 0;
  int n_errors = 0;
  int fin_cnt  = 0;

  crono_countdown_ctrl #(.TICK_DIV(4), .RING_SECS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .programar    (programar),
    .iniciar      (iniciar),
    .load_valid   (load_valid),
    .load_hh      (load_hh),
    .load_mm      (load_mm),
    .load_ss      (load_ss),
    .ring_ack     (ring_ack),
    .hh           (hh),
    .mm           (mm),
    .ss           (ss),
    .crono_activo (crono_activo),
    .ring         (ring),
    .finalizo     (finalizo),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_prog();
    programar = 1'b1; step(); programar = 1'b0;
  endtask

  task automatic pulse_start();
    iniciar = 1'b1; step(); iniciar = 1'b0;
  endtask

  task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load_hh = h; load_mm = m; load_ss = s;
    load_valid = 1'b1; step(); load_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_state", {6'd0, state}, 8'd0);
    chk("rst_ss", ss, 8'h00);
    chk("rst_ring", {7'd0, ring}, 8'd0);
    chk("rst_activo", {7'd0, crono_activo}, 8'd0);
    chk("rst_fin", {7'd0, finalizo}, 8'd0);
    $display("reset released: state=%0d", state);

    // IDLE ignores iniciar
    pulse_start();
    chk("idle_ignore", {6'd0, state}, 8'd0);

    // 00:00:03 countdown, finish pulse and 8-cycle ring
    pulse_prog();
    chk("prog_state", {6'd0, state}, 8'd1);
    load(8'h00, 8'h00, 8'h03);
    chk("load_ss3", ss, 8'h03);
    pulse_start();
    chk("run_state", {6'd0, state}, 8'd2);
    chk("run_activo", {7'd0, crono_activo}, 8'd1);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (finalizo) fin_cnt++;
      if (i == 3)  chk("ss_hold3", ss, 8'h03);
      if (i == 4)  chk("ss_2", ss, 8'h02);
      if (i == 8)  chk("ss_1", ss, 8'h01);
      if (i == 12) begin
        chk("ss_0", ss, 8'h00);
        chk("ring_state", {6'd0, state}, 8'd3);
        chk("ring_on", {7'd0, ring}, 8'd1);
        chk("fin_pulse", {7'd0, finalizo}, 8'd1);
        chk("ring_activo", {7'd0, crono_activo}, 8'd0);
      end
      if (i == 19) chk("ring_hold", {7'd0, ring}, 8'd1);
      if (i == 20) begin
        chk("ring_to_idle", {6'd0, state}, 8'd0);
        chk("ring_off", {7'd0, ring}, 8'd0);
      end
    end
    chk("fin_once", 8'(fin_cnt), 8'd1);
    $display("countdown 3s: ss=%0h state=%0d finalizo pulses=%0d", ss, state, fin_cnt);

    // Borrow 01:00:00 -> 00:59:59, then reprogram and reject illegal loads
    pulse_prog();
    load(8'h01, 8'h00, 8'h00);
    pulse_start();
    repeat (4) step();
    chk("borrow_hh", hh, 8'h00);
    chk("borrow_mm", mm, 8'h59);
    chk("borrow_ss", ss, 8'h59);
    pulse_prog();
    chk("run_to_prog", {6'd0, state}, 8'd1);
    chk("kept_mm", mm, 8'h59);
    load(8'h00, 8'h60, 8'h00);
    chk("bad_mm", mm, 8'h59);
    load(8'h24, 8'h00, 8'h00);
    chk("bad_hh", hh, 8'h00);
    load(8'h00, 8'h00, 8'h0A);
    chk("bad_ss", ss, 8'h59);
    $display("borrow/illegal: %0h:%0h:%0h", hh, mm, ss);

    // Zero start refused; load together with iniciar starts
    load(8'h00, 8'h00, 8'h00);
    pulse_start();
    chk("zero_start", {6'd0, state}, 8'd1);
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h05;
    load_valid = 1'b1; iniciar = 1'b1; step();
    load_valid = 1'b0; iniciar = 1'b0;
    chk("load_start", {6'd0, state}, 8'd2);
    chk("load_start_ss", ss, 8'h05);
    $display("zero/load+start: state=%0d ss=%0h", state, ss);

    // Reset mid-RUN at 00:01:30
    pulse_prog();
    load(8'h00, 8'h01, 8'h30);
    pulse_start();
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_state", {6'd0, state}, 8'd0);
    chk("midrst_mm", mm, 8'h00);
    chk("midrst_ss", ss, 8'h00);
    chk("midrst_activo", {7'd0, crono_activo}, 8'd0);
    $display("reset mid-run: state=%0d", state);

    // ring_ack in the 3rd ring cycle
    pulse_prog();
    load(8'h00, 8'h00, 8'h01);
    pulse_start();
    repeat (4) step();
    chk("ack_ring1", {6'd0, state}, 8'd3);
    step(); step();
    chk("ack_ring3", {7'd0, ring}, 8'd1);
    ring_ack = 1'b1; step(); ring_ack = 1'b0;
    chk("ack_idle", {6'd0, state}, 8'd0);
    chk("ack_ring_off", {7'd0, ring}, 8'd0);
    $display("ring_ack: state=%0d ring=%0d", state, ring);

    // Pause behaviour (or iniciar ignored in RUN)
    pulse_prog();
    load(8'h00, 8'h00, 8'h06);
    pulse_start();
    repeat (4) step();
    chk("p_ss5", ss, 8'h05);
    step();
`ifdef CRONO_PAUSE_EN
    pulse_start();
    chk("pause_state", {6'd0, state}, 8'd2);
    chk("pause_activo", {7'd0, crono_activo}, 8'd1);
    repeat (20) step();
    chk("pause_hold", ss, 8'h05);
    pulse_start();
    step(); step();
    chk("resume_pre", ss, 8'h05);
    step();
    chk("resume_tick", ss, 8'h04);
    $display("pause/resume: ss=%0h", ss);
`else
    pulse_start();
    chk("ini_ignored", {6'd0, state}, 8'd2);
    step(); step();
    chk("ini_tick", ss, 8'h04);
    $display("iniciar in RUN ignored: ss=%0h", ss);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
